// File: rtl/button_debouncer_if.sv
// Pin-side bundle for button_debouncer: raw button level in, debounced level out.
// With DEBOUNCE_EDGE_PULSE_EN defined, the one-cycle edge pulses are carried here too.
interface button_debouncer_if;
    logic button_in;
    logic DB_out;
`ifdef DEBOUNCE_EDGE_PULSE_EN
    logic DB_rise;
    logic DB_fall;

    modport master (output button_in, input  DB_out, DB_rise, DB_fall);
    modport slave  (input  button_in, output DB_out, DB_rise, DB_fall);
`else
    modport master (output button_in, input  DB_out);
    modport slave  (input  button_in, output DB_out);
`endif
endinterface

// File: rtl/button_debouncer.sv
// Two-flop synchronizer plus stability counter for one push-button input.
// Optional DEBOUNCE_EDGE_PULSE_EN adds registered one-cycle rise/fall pulses.
module button_debouncer #(
    parameter int unsigned STABLE_CYCLES = 100
) (
    input  logic              clk,
    input  logic              n_reset,
    button_debouncer_if.slave db
);

    localparam int unsigned          CNT_W    = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             sync_1_q;
    logic             sync_2_q;
    logic             db_out_q;
    logic             db_out_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sync_1_q <= 1'b0;
            sync_2_q <= 1'b0;
            db_out_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_1_q <= db.button_in;
            sync_2_q <= sync_1_q;
            db_out_q <= db_out_d;
            cnt_q    <= cnt_d;
        end
    end

    // Any sample matching the current output restarts the stability window.
    always_comb begin
        db_out_d = db_out_q;
        cnt_d    = cnt_q;
        if (sync_2_q == db_out_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            db_out_d = sync_2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign db.DB_out = db_out_q;

`ifdef DEBOUNCE_EDGE_PULSE_EN
    logic db_out_dly_q;
    logic rise_q;
    logic fall_q;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            db_out_dly_q <= 1'b0;
            rise_q       <= 1'b0;
            fall_q       <= 1'b0;
        end else begin
            db_out_dly_q <= db_out_q;
            rise_q       <= db_out_q & ~db_out_dly_q;
            fall_q       <= ~db_out_q & db_out_dly_q;
        end
    end

    assign db.DB_rise = rise_q;
    assign db.DB_fall = fall_q;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: step table, hand-written reset sequences and random
// bursts, all compared cycle by cycle against a run-length reference model.
module tb_button_debouncer;

    localparam int unsigned STABLE = 100;

    logic clk;
    logic n_reset;
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 0;

    button_debouncer_if dut_if ();

    button_debouncer #(.STABLE_CYCLES(STABLE)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .db      (dut_if.slave)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the level seen two edges after sampling must differ from
    // the output for STABLE consecutive clocks before the output takes it.
    logic m_p0 = 1'b0, m_p1 = 1'b0;
    logic m_db = 1'b0, m_db_prev = 1'b0;
    logic m_rise = 1'b0, m_fall = 1'b0;
    int   m_run = 0;

    always @(posedge clk or negedge n_reset) begin
        logic v;
        if (!n_reset) begin
            m_p0 = 1'b0; m_p1 = 1'b0; m_db = 1'b0; m_db_prev = 1'b0;
            m_rise = 1'b0; m_fall = 1'b0; m_run = 0;
        end else begin
            v = m_p1;
            m_p1 = m_p0;
            m_p0 = (dut_if.button_in === 1'b1);
            m_rise = m_db & ~m_db_prev;
            m_fall = ~m_db & m_db_prev;
            m_db_prev = m_db;
            if (v == m_db) m_run = 0;
            else begin
                m_run = m_run + 1;
                if (m_run == int'(STABLE)) begin
                    m_db = v;
                    m_run = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_db", dut_if.DB_out, m_db);
`ifdef DEBOUNCE_EDGE_PULSE_EN
            check("model_rise", dut_if.DB_rise, m_rise);
            check("model_fall", dut_if.DB_fall, m_fall);
`endif
        end
    end

    typedef struct {
        logic        lvl;
        int unsigned n;
        logic        exp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        // bounce rejection from 0, then steady press
        vecs.push_back('{1'b1, 20, 1'b0});
        vecs.push_back('{1'b0, 40, 1'b0});
        vecs.push_back('{1'b1, 40, 1'b0});
        vecs.push_back('{1'b0, 40, 1'b0});
        vecs.push_back('{1'b1, 101, 1'b0});
        vecs.push_back('{1'b1, 1, 1'b1});
        // clean hold
        vecs.push_back('{1'b1, 2000, 1'b1});
        // short low of 200 clocks, then return
        vecs.push_back('{1'b0, 101, 1'b1});
        vecs.push_back('{1'b0, 1, 1'b0});
        vecs.push_back('{1'b0, 98, 1'b0});
        vecs.push_back('{1'b1, 101, 1'b0});
        vecs.push_back('{1'b1, 1, 1'b1});
        // release bounce
        vecs.push_back('{1'b0, 20, 1'b1});
        vecs.push_back('{1'b1, 40, 1'b1});
        vecs.push_back('{1'b0, 40, 1'b1});
        vecs.push_back('{1'b1, 40, 1'b1});
        vecs.push_back('{1'b0, 101, 1'b1});
        vecs.push_back('{1'b0, 1, 1'b0});
        vecs.push_back('{1'b0, 200, 1'b0});

        n_reset = 1'b1;
        dut_if.button_in = 1'b0;
        #2 n_reset = 1'b0;
        dut_if.button_in = 1'bx;
        #1 chk_en = 1;
        check("reset_db", dut_if.DB_out, 1'b0);
        repeat (10) @(negedge clk);
        check("reset_db_end", dut_if.DB_out, 1'b0);
        dut_if.button_in = 1'b0;
        n_reset = 1'b1;
        repeat (2000) @(negedge clk);
        check("idle_low", dut_if.DB_out, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            dut_if.button_in = vecs[i].lvl;
            repeat (vecs[i].n) @(negedge clk);
            check($sformatf("vec%0d", i), dut_if.DB_out, vecs[i].exp);
        end

        for (int b = 0; b < 60; b++) begin
            int unsigned len;
            len = ($urandom_range(0, 9) < 7) ? $urandom_range(1, 30) : $urandom_range(90, 160);
            dut_if.button_in = 1'($urandom_range(0, 1));
            repeat (len) @(negedge clk);
        end

        // async reset from a debounced high output
        dut_if.button_in = 1'b1;
        repeat (150) @(negedge clk);
        check("hold_high", dut_if.DB_out, 1'b1);
        #3 n_reset = 1'b0;
        #1 check("async_reset", dut_if.DB_out, 1'b0);
        repeat (5) @(negedge clk);
        n_reset = 1'b1;

        // input already high at release, then reset mid-count
        repeat (50) @(negedge clk);
        check("midcount_before", dut_if.DB_out, 1'b0);
        n_reset = 1'b0;
        #1 check("midcount_reset", dut_if.DB_out, 1'b0);
        repeat (5) @(negedge clk);
        n_reset = 1'b1;
        repeat (101) @(negedge clk);
        check("midcount_101", dut_if.DB_out, 1'b0);
        @(negedge clk);
        check("midcount_102", dut_if.DB_out, 1'b1);
        repeat (20) @(negedge clk);

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
